// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: drives the shared stop vector,
// sequences exception/watchdog flushes. Optional stall counter via `PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int          TIMEOUT    = 255,
   parameter logic [31:0] ERR_VECTOR = 32'h0000_0040
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   output logic [5:0]  stop,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        timeout_err,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   localparam bit         WD_EN   = (TIMEOUT != 0);
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wd_cnt_q, wd_cnt_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic        in_flush, wd_fire, trig, any_req;

   // The watchdog fires on the TIMEOUT-th consecutive MEM stall; FLUSH masks everything.
   always_comb begin
      in_flush = (state_q == FLUSH);
      any_req  = stallreq_id | stallreq_ex | stallreq_mem;
      wd_fire  = WD_EN && !in_flush && stallreq_mem && (wd_cnt_q == WD_LAST);
      trig     = !in_flush && (exc_req || wd_fire);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (trig)          state_d = FLUSH;
      else if (in_flush) state_d = RUN;
      else if (any_req)  state_d = STALL;
      else               state_d = RUN;
   end

   always_comb begin
      stop        = 6'b000000;
      flush       = in_flush;
      timeout_err = wd_fire;
      if (in_flush)          stop = 6'b000000;
      else if (trig)         stop = 6'b111111;
      else if (stallreq_mem) stop = 6'b011111;
      else if (stallreq_ex)  stop = 6'b001111;
      else if (stallreq_id)  stop = 6'b000111;
   end

   // Exception wins over a simultaneous watchdog fire for the redirect target.
   always_comb begin
      new_pc_d = new_pc_q;
      if (trig) new_pc_d = exc_req ? exc_pc : ERR_VECTOR;
      wd_cnt_d = (in_flush || !stallreq_mem || wd_fire) ? 8'd0 : wd_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         new_pc_q <= 32'd0;
         wd_cnt_q <= 8'd0;
      end else begin
         new_pc_q <= new_pc_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   assign new_pc = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Freeze cycles count as stalls; the counter saturates rather than wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stop[0] && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= 32'd0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (TIMEOUT=4): a reference model pushes expected
// outputs per cycle, which are popped and compared against the DUT mid-cycle.
module tb_pipe_ctrl;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst, stallreq_id, stallreq_ex, stallreq_mem, exc_req;
   logic [31:0] exc_pc;
   logic [5:0]  stop;
   logic        flush, timeout_err;
   logic [31:0] new_pc, stall_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [5:0]  stop;
      logic        flush;
      logic [31:0] new_pc;
      logic        to;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];

   int          m_state;
   int          m_wd;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;

   pipe_ctrl #(.TIMEOUT(TIMEOUT), .ERR_VECTOR(32'h0000_0040)) dut (
      .clk(clk), .rst(rst),
      .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .exc_req(exc_req), .exc_pc(exc_pc),
      .stop(stop), .flush(flush), .new_pc(new_pc),
      .timeout_err(timeout_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle of inputs, predicts outputs, compares, then advances the model.
   task automatic applyStimulus(input logic r, input logic id, input logic ex,
                                input logic mem, input logic exc, input logic [31:0] pc);
      exp_t e, o;
      logic in_flush, fire, trig;
      @(negedge clk);
      rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
      exc_req = exc; exc_pc = pc;
      in_flush = (m_state == 2);
      fire     = !in_flush && mem && (m_wd == TIMEOUT - 1);
      trig     = !in_flush && (exc || fire);
      if (in_flush)  e.stop = 6'b000000;
      else if (trig) e.stop = 6'b111111;
      else if (mem)  e.stop = 6'b011111;
      else if (ex)   e.stop = 6'b001111;
      else if (id)   e.stop = 6'b000111;
      else           e.stop = 6'b000000;
      e.flush  = in_flush;
      e.new_pc = m_pc;
      e.to     = fire;
      e.cnt    = m_cnt;
      sb.push_back(e);
      #2;
      o = sb.pop_front();
      checkOutput("stop", {26'd0, stop}, {26'd0, o.stop});
      checkOutput("flush", {31'd0, flush}, {31'd0, o.flush});
      checkOutput("new_pc", new_pc, o.new_pc);
      checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, o.to});
      checkOutput("stall_cnt", stall_cnt, o.cnt);
      @(posedge clk);
      if (r) begin
         m_state = 0; m_wd = 0; m_pc = 32'd0; m_cnt = 32'd0;
      end else begin
`ifdef PIPE_CTRL_PERF_EN
         if (e.stop[0] && !e.flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
         if (trig) begin
            m_pc = exc ? pc : 32'h0000_0040;
            m_state = 2;
         end else if (in_flush) m_state = 0;
         else m_state = (id | ex | mem) ? 1 : 0;
         m_wd = (in_flush || !mem || fire) ? 0 : m_wd + 1;
      end
   endtask

   initial begin
      rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
      exc_req = 0; exc_pc = 32'd0;
      m_state = 0; m_wd = 0; m_pc = 32'd0; m_cnt = 32'd0;
      repeat (2) @(posedge clk);

      applyStimulus(1, 0, 0, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      applyStimulus(0, 1, 0, 0, 0, 32'd0);
      applyStimulus(0, 1, 0, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      applyStimulus(0, 1, 1, 1, 0, 32'd0);
      applyStimulus(0, 1, 1, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      applyStimulus(0, 0, 0, 0, 1, 32'h0000_0180);
      #2;
      checkOutput("exc_flush", {31'd0, flush}, 32'd1);
      checkOutput("exc_new_pc", new_pc, 32'h0000_0180);
      applyStimulus(0, 0, 0, 0, 1, 32'h0000_0200);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);
      checkOutput("exc_ignored_pc", new_pc, 32'h0000_0180);

      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 32'd0);
      #2;
      checkOutput("wd_flush", {31'd0, flush}, 32'd1);
      checkOutput("wd_new_pc", new_pc, 32'h0000_0040);
      applyStimulus(0, 0, 0, 1, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 32'd0);
      applyStimulus(0, 0, 0, 1, 1, 32'h0000_0300);
      #2;
      checkOutput("both_new_pc", new_pc, 32'h0000_0300);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      applyStimulus(0, 0, 0, 0, 1, 32'h0000_0400);
      applyStimulus(1, 0, 0, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);
      checkOutput("rst_flush_pc", new_pc, 32'd0);

      applyStimulus(1, 0, 0, 0, 1, 32'h0000_0500);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);

      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      checkOutput("perf_cnt5", stall_cnt, 32'd5);
`endif

      for (int i = 0; i < 200; i++)
         applyStimulus($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 9) == 0, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
